// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: opcodes, hazard FSM encodings and the
// hazard-control bundle used by the stall/flush controller.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_NOP   = 6'b100000
    } opcode_e;

    localparam logic [1:0] HS_RUN         = 2'd0;
    localparam logic [1:0] HS_MEM_WAIT    = 2'd1;
    localparam logic [1:0] HS_TIMEOUT_REL = 2'd2;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_bubble;
        logic id_nop;
        logic if_flush;
        logic ex_flush;
    } hazard_ctrl_t;

    // Instructions whose rt field is read as a source operand.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, branch flushes and a data-memory
// wait FSM with timeout release, plus saturating stall/flush statistics.
module hazard_control #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Opcode_ID,
    input  logic [4:0]       RegisterRs_ID,
    input  logic [4:0]       RegisterRt_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       RegisterRt_EX,
    input  logic             Branch_MEM,
    input  logic             Zero_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             DMem_Ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             ID_Control_NOP,
    output logic             IF_Flush,
    output logic             EX_Flush,
    output logic [1:0]       Hazard_State,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemTimeout_Err
);

    import mips_pkg::*;

    // The wait count is cleared on entry, so the last MEM_WAIT cycle sees MEM_TIMEOUT-2
    // and the access has then been frozen for exactly MEM_TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 2);

    logic [1:0]   state;
    logic [7:0]   wait_cnt;
    logic         mem_acc;
    logic         taken;
    logic         lu;
    logic         freeze;
    logic         lu_stall;
    logic         stall_inc;
    logic         flush_inc;
    hazard_ctrl_t ctrl;

    assign mem_acc = MemRead_MEM | MemWrite_MEM;
    assign taken   = Branch_MEM & Zero_MEM;

    assign lu = MemRead_EX && (RegisterRt_EX != 5'd0) &&
                ((RegisterRt_EX == RegisterRs_ID) ||
                 (uses_rt(Opcode_ID) && (RegisterRt_EX == RegisterRt_ID)));

    // TIMEOUT_REL is absent here on purpose: that cycle abandons the access.
    assign freeze = ((state == HS_RUN) && mem_acc && !DMem_Ready) ||
                    ((state == HS_MEM_WAIT) && !DMem_Ready);

    assign lu_stall  = lu && !freeze && !taken;
    assign stall_inc = freeze || lu_stall;
    assign flush_inc = taken && !freeze;

    always_comb begin
        // NOTE: every field gets a default first so no path through the block can infer a latch.
        ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
                 memwb_bubble: 1'b0, id_nop: 1'b0, if_flush: 1'b0, ex_flush: 1'b0};
        if (Reset) begin
            ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0, exmem_write: 1'b0,
                     memwb_bubble: 1'b1, id_nop: 1'b1, if_flush: 1'b0, ex_flush: 1'b0};
        end else if (freeze) begin
            ctrl.pc_write     = 1'b0;
            ctrl.ifid_write   = 1'b0;
            ctrl.idex_write   = 1'b0;
            ctrl.exmem_write  = 1'b0;
            ctrl.memwb_bubble = 1'b1;
        end else if (taken) begin
            ctrl.if_flush = 1'b1;
            ctrl.id_nop   = 1'b1;
            ctrl.ex_flush = 1'b1;
        end else if (lu_stall) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.id_nop     = 1'b1;
        end
    end

    assign PCWrite        = ctrl.pc_write;
    assign IFID_Write     = ctrl.ifid_write;
    assign IDEX_Write     = ctrl.idex_write;
    assign EXMEM_Write    = ctrl.exmem_write;
    assign MEMWB_Bubble   = ctrl.memwb_bubble;
    assign ID_Control_NOP = ctrl.id_nop;
    assign IF_Flush       = ctrl.if_flush;
    assign EX_Flush       = ctrl.ex_flush;
    assign Hazard_State   = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= HS_RUN;
            wait_cnt       <= '0;
            MemTimeout_Err <= 1'b0;
        end else begin
            case (state)
                HS_RUN: begin
                    if (mem_acc && !DMem_Ready) begin
                        state    <= HS_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                HS_MEM_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (DMem_Ready) begin
                        state <= HS_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state          <= HS_TIMEOUT_REL;
                        MemTimeout_Err <= 1'b1;
                    end
                end
                default: state <= HS_RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: decode table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_hazard_control;

    import mips_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Bubble, ID_Control_NOP, IF_Flush, EX_Flush}
    localparam logic [7:0] C_RUN    = 8'b1111_0000;
    localparam logic [7:0] C_LU     = 8'b0011_0100;
    localparam logic [7:0] C_TAKEN  = 8'b1111_0111;
    localparam logic [7:0] C_FREEZE = 8'b0000_1000;
    localparam logic [7:0] C_RESET  = 8'b0000_1100;

    logic             Clk = 1'b0;
    logic             Reset;
    logic [5:0]       Opcode_ID;
    logic [4:0]       RegisterRs_ID;
    logic [4:0]       RegisterRt_ID;
    logic             MemRead_EX;
    logic [4:0]       RegisterRt_EX;
    logic             Branch_MEM;
    logic             Zero_MEM;
    logic             MemRead_MEM;
    logic             MemWrite_MEM;
    logic             DMem_Ready;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IDEX_Write;
    logic             EXMEM_Write;
    logic             MEMWB_Bubble;
    logic             ID_Control_NOP;
    logic             IF_Flush;
    logic             EX_Flush;
    logic [1:0]       Hazard_State;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    logic             MemTimeout_Err;
    logic [7:0]       dut_ctrl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: an access times out after MEM_TIMEOUT frozen cycles.
    bit m_in_wait;
    int m_waited;
    bit m_release;
    int m_stall;
    int m_flush;
    bit m_err;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr_ex;
        logic [4:0] rt_ex;
        logic       br;
        logic       zero;
        logic       mem_rd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    hazard_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Opcode_ID      (Opcode_ID),
        .RegisterRs_ID  (RegisterRs_ID),
        .RegisterRt_ID  (RegisterRt_ID),
        .MemRead_EX     (MemRead_EX),
        .RegisterRt_EX  (RegisterRt_EX),
        .Branch_MEM     (Branch_MEM),
        .Zero_MEM       (Zero_MEM),
        .MemRead_MEM    (MemRead_MEM),
        .MemWrite_MEM   (MemWrite_MEM),
        .DMem_Ready     (DMem_Ready),
        .PCWrite        (PCWrite),
        .IFID_Write     (IFID_Write),
        .IDEX_Write     (IDEX_Write),
        .EXMEM_Write    (EXMEM_Write),
        .MEMWB_Bubble   (MEMWB_Bubble),
        .ID_Control_NOP (ID_Control_NOP),
        .IF_Flush       (IF_Flush),
        .EX_Flush       (EX_Flush),
        .Hazard_State   (Hazard_State),
        .StallCount     (StallCount),
        .FlushCount     (FlushCount),
        .MemTimeout_Err (MemTimeout_Err)
    );

    assign dut_ctrl = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write,
                       MEMWB_Bubble, ID_Control_NOP, IF_Flush, EX_Flush};

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        Opcode_ID     = OP_RTYPE;
        RegisterRs_ID = 5'd0;
        RegisterRt_ID = 5'd0;
        MemRead_EX    = 1'b0;
        RegisterRt_EX = 5'd0;
        Branch_MEM    = 1'b0;
        Zero_MEM      = 1'b0;
        MemRead_MEM   = 1'b0;
        MemWrite_MEM  = 1'b0;
        DMem_Ready    = 1'b1;
    endtask

    task automatic model_reset();
        m_in_wait = 1'b0;
        m_waited  = 0;
        m_release = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
        m_err     = 1'b0;
    endtask

    // Leaves the bench one time unit after a rising edge with Reset released.
    task automatic do_reset();
        Reset = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rt_ex, input logic [4:0] rs);
        MemRead_EX    = 1'b1;
        RegisterRt_EX = rt_ex;
        Opcode_ID     = OP_RTYPE;
        RegisterRs_ID = rs;
        RegisterRt_ID = 5'd30;
    endtask

    initial begin
        logic [7:0]  e_ctrl;
        logic [1:0]  e_state;
        logic [31:0] e_pack;
        logic [31:0] a_pack;
        bit          e_freeze;
        bit          e_lu;
        bit          e_taken;
        int          exp_stall;
        int          exp_flush;

        vecs[0]  = '{OP_RTYPE, 5'd1, 5'd2, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[1]  = '{OP_RTYPE, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[2]  = '{OP_RTYPE, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[3]  = '{OP_RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[4]  = '{OP_LW,    5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[5]  = '{OP_LW,    5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[6]  = '{OP_SW,    5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[7]  = '{OP_BEQ,   5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[8]  = '{6'b001000, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[9]  = '{OP_RTYPE, 5'd4, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[10] = '{OP_BEQ,   5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, C_TAKEN};
        vecs[11] = '{OP_BEQ,   5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, C_LU};
        vecs[12] = '{OP_RTYPE, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, C_RUN};
        vecs[13] = '{OP_NOP,   5'd2, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_RUN};

        // Reset values before any clock edge.
        Reset = 1'b1;
        clear_inputs();
        #2;
        check("reset_ctrl", 32'(dut_ctrl), 32'(C_RESET));
        check("reset_state", 32'(Hazard_State), 32'(HS_RUN));
        check("reset_counts", {StallCount, FlushCount}, 32'd0);
        check("reset_err", 32'(MemTimeout_Err), 32'd0);
        do_reset();

        // Single-cycle decode table, all in RUN with memory idle or ready.
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 14; i++) begin
            clear_inputs();
            Opcode_ID     = vecs[i].op;
            RegisterRs_ID = vecs[i].rs;
            RegisterRt_ID = vecs[i].rt;
            MemRead_EX    = vecs[i].mr_ex;
            RegisterRt_EX = vecs[i].rt_ex;
            Branch_MEM    = vecs[i].br;
            Zero_MEM      = vecs[i].zero;
            MemRead_MEM   = vecs[i].mem_rd;
            if (vecs[i].exp == C_LU) exp_stall++;
            if (vecs[i].exp == C_TAKEN) exp_flush++;
            @(negedge Clk);
            check($sformatf("vec%0d", i), 32'(dut_ctrl), 32'(vecs[i].exp));
            next_cycle();
        end
        clear_inputs();
        @(negedge Clk);
        check("table_stall_count", 32'(StallCount), 32'(exp_stall));
        check("table_flush_count", 32'(FlushCount), 32'(exp_flush));
        next_cycle();

        // Load-use stall lasts one cycle; $0 never stalls.
        do_reset();
        set_lu(5'd5, 5'd5);
        @(negedge Clk);
        check("lu_ctrl", 32'(dut_ctrl), 32'(C_LU));
        check("lu_stall_before", 32'(StallCount), 32'd0);
        next_cycle();
        clear_inputs();
        @(negedge Clk);
        check("lu_released", 32'(dut_ctrl), 32'(C_RUN));
        check("lu_stall_after", 32'(StallCount), 32'd1);
        next_cycle();
        set_lu(5'd0, 5'd0);
        @(negedge Clk);
        check("lu_zero_reg", 32'(dut_ctrl), 32'(C_RUN));
        next_cycle();

        // Taken branch overrides a simultaneous load-use.
        set_lu(5'd5, 5'd5);
        Branch_MEM = 1'b1;
        Zero_MEM   = 1'b1;
        @(negedge Clk);
        check("br_lu_ctrl", 32'(dut_ctrl), 32'(C_TAKEN));
        next_cycle();
        clear_inputs();
        @(negedge Clk);
        check("br_flush_count", 32'(FlushCount), 32'd1);
        check("br_stall_unchanged", 32'(StallCount), 32'd1);
        next_cycle();

        // Memory wait: three frozen cycles, then the ready cycle advances.
        do_reset();
        MemRead_MEM = 1'b1;
        DMem_Ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check($sformatf("wait_state%0d", i), 32'(Hazard_State), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("wait_ctrl%0d", i), 32'(dut_ctrl), 32'(C_FREEZE));
            next_cycle();
        end
        DMem_Ready = 1'b1;
        @(negedge Clk);
        check("wait_ready_state", 32'(Hazard_State), 32'd1);
        check("wait_ready_ctrl", 32'(dut_ctrl), 32'(C_RUN));
        next_cycle();
        clear_inputs();
        @(negedge Clk);
        check("wait_done_state", 32'(Hazard_State), 32'd0);
        check("wait_stall_count", 32'(StallCount), 32'd3);
        next_cycle();

        // Timeout: MEM_TIMEOUT frozen cycles, one release cycle, sticky error.
        do_reset();
        MemWrite_MEM = 1'b1;
        DMem_Ready   = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge Clk);
            check($sformatf("to_ctrl%0d", i), 32'(dut_ctrl), 32'(C_FREEZE));
            check($sformatf("to_err%0d", i), 32'(MemTimeout_Err), 32'd0);
            next_cycle();
        end
        @(negedge Clk);
        check("to_rel_state", 32'(Hazard_State), 32'd2);
        check("to_rel_ctrl", 32'(dut_ctrl), 32'(C_RUN));
        check("to_rel_err", 32'(MemTimeout_Err), 32'd1);
        next_cycle();
        clear_inputs();
        @(negedge Clk);
        check("to_back_state", 32'(Hazard_State), 32'd0);
        check("to_stall_count", 32'(StallCount), 32'(MEM_TIMEOUT));
        repeat (3) next_cycle();
        @(negedge Clk);
        check("to_err_sticky", 32'(MemTimeout_Err), 32'd1);
        next_cycle();

        // Branch waiting behind a frozen access flushes and counts once.
        do_reset();
        MemRead_MEM = 1'b1;
        DMem_Ready  = 1'b0;
        Branch_MEM  = 1'b1;
        Zero_MEM    = 1'b1;
        @(negedge Clk);
        check("brfz_ctrl", 32'(dut_ctrl), 32'(C_FREEZE));
        next_cycle();
        @(negedge Clk);
        check("brfz_flush_held", 32'(FlushCount), 32'd0);
        next_cycle();
        DMem_Ready = 1'b1;
        @(negedge Clk);
        check("brfz_release_ctrl", 32'(dut_ctrl), 32'(C_TAKEN));
        next_cycle();
        clear_inputs();
        @(negedge Clk);
        check("brfz_flush_count", 32'(FlushCount), 32'd1);
        check("brfz_stall_count", 32'(StallCount), 32'd2);
        next_cycle();

        // Asynchronous reset in the middle of a wait.
        do_reset();
        MemRead_MEM = 1'b1;
        DMem_Ready  = 1'b0;
        next_cycle();
        next_cycle();
        #2 Reset = 1'b1;
        #1;
        check("arst_state", 32'(Hazard_State), 32'd0);
        check("arst_counts", {StallCount, FlushCount}, 32'd0);
        check("arst_ctrl", 32'(dut_ctrl), 32'(C_RESET));
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("arst_release_ctrl", 32'(dut_ctrl), 32'(C_FREEZE));
        next_cycle();
        check("arst_resume_state", 32'(Hazard_State), 32'd1);
        clear_inputs();
        next_cycle();

        // Counter saturation.
        do_reset();
        Branch_MEM = 1'b1;
        Zero_MEM   = 1'b1;
        repeat (CNT_MAX + 5) next_cycle();
        check("sat_flush", 32'(FlushCount), 32'(CNT_MAX));
        clear_inputs();
        set_lu(5'd9, 5'd9);
        repeat (CNT_MAX + 5) next_cycle();
        check("sat_stall", 32'(StallCount), 32'(CNT_MAX));
        check("sat_flush_hold", 32'(FlushCount), 32'(CNT_MAX));

        // Randomized run against the reference model, with periodic resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) do_reset();
            Opcode_ID     = ($urandom_range(0, 5) == 0) ? OP_LW :
                            ($urandom_range(0, 3) == 0) ? OP_SW :
                            ($urandom_range(0, 2) == 0) ? OP_BEQ :
                            ($urandom_range(0, 1) == 0) ? OP_NOP : OP_RTYPE;
            RegisterRs_ID = 5'($urandom_range(0, 3));
            RegisterRt_ID = 5'($urandom_range(0, 3));
            MemRead_EX    = 1'($urandom_range(0, 1));
            RegisterRt_EX = 5'($urandom_range(0, 3));
            Branch_MEM    = ($urandom_range(0, 3) == 0);
            Zero_MEM      = 1'($urandom_range(0, 1));
            MemRead_MEM   = ($urandom_range(0, 4) == 0);
            MemWrite_MEM  = ($urandom_range(0, 9) == 0);
            DMem_Ready    = ($urandom_range(0, 99) < 55);

            e_freeze = !m_release && !DMem_Ready && (m_in_wait || MemRead_MEM || MemWrite_MEM);
            e_taken  = Branch_MEM && Zero_MEM;
            e_lu     = MemRead_EX && (RegisterRt_EX != 0) &&
                       ((RegisterRt_EX == RegisterRs_ID) ||
                        ((Opcode_ID == 6'b000000 || Opcode_ID == 6'b101011 || Opcode_ID == 6'b000100) &&
                         (RegisterRt_EX == RegisterRt_ID)));
            if (e_freeze) e_ctrl = C_FREEZE;
            else if (e_taken) e_ctrl = C_TAKEN;
            else if (e_lu) e_ctrl = C_LU;
            else e_ctrl = C_RUN;
            e_state = m_release ? 2'd2 : (m_in_wait ? 2'd1 : 2'd0);

            @(negedge Clk);
            e_pack = 32'({e_ctrl, e_state, m_err, CNT_W'(m_stall), CNT_W'(m_flush)});
            a_pack = 32'({dut_ctrl, Hazard_State, MemTimeout_Err, StallCount, FlushCount});
            check($sformatf("rand%0d", c), a_pack, e_pack);

            if (e_freeze || (e_lu && !e_taken)) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
            if (e_taken && !e_freeze) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            if (m_release) begin
                m_release = 1'b0;
                m_in_wait = 1'b0;
                m_waited  = 0;
            end else if (e_freeze) begin
                m_waited = m_in_wait ? m_waited + 1 : 1;
                if (m_waited == MEM_TIMEOUT) begin
                    m_release = 1'b1;
                    m_err     = 1'b1;
                    m_in_wait = 1'b0;
                end else begin
                    m_in_wait = 1'b1;
                end
            end else begin
                m_in_wait = 1'b0;
                m_waited  = 0;
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS32 core.
- Generates ID_Control_NOP, the bubble request consumed by the ID-stage control decoder.
- Also generates the PC and pipeline-register write enables and the branch flush signals.
- Adds a data-memory wait handshake with timeout, plus saturating stall/flush event counters.

Parameters:
CNT_W, 16, width of the StallCount and FlushCount counters
MEM_TIMEOUT, 64, cycles in MEM_WAIT before the timeout error fires (valid range 2..255)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Opcode_ID  in  6  opcode of the instruction in ID
RegisterRs_ID  in  5  rs field in ID
RegisterRt_ID  in  5  rt field in ID
MemRead_EX  in  1  instruction in EX is a load
RegisterRt_EX  in  5  load destination register in EX
Branch_MEM  in  1  BEQ in MEM
Zero_MEM  in  1  ALU zero flag in MEM
MemRead_MEM  in  1  load in MEM
MemWrite_MEM  in  1  store in MEM
DMem_Ready  in  1  data memory completes the access this cycle
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
IDEX_Write  out  1  ID/EX register enable
EXMEM_Write  out  1  EX/MEM register enable
MEMWB_Bubble  out  1  load a bubble into MEM/WB
ID_Control_NOP  out  1  force NOP control out of the ID decoder
IF_Flush  out  1  zero IF/ID
EX_Flush  out  1  zero EX/MEM control
Hazard_State  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 TIMEOUT_REL
StallCount  out  CNT_W  saturating count of stall/freeze cycles
FlushCount  out  CNT_W  saturating count of branch flushes
MemTimeout_Err  out  1  sticky memory-timeout flag

Behaviour:
- Definitions: mem_acc = MemRead_MEM | MemWrite_MEM; taken = Branch_MEM & Zero_MEM.
- uses_rt is true for opcodes 000000, 101011 and 000100 only.
- lu = MemRead_EX & (RegisterRt_EX != 0) & ((RegisterRt_EX == RegisterRs_ID) | (uses_rt & (RegisterRt_EX == RegisterRt_ID))).
- Default outputs: all write enables 1; ID_Control_NOP, IF_Flush, EX_Flush and MEMWB_Bubble 0.
- freeze = (RUN & mem_acc & ~DMem_Ready) | (MEM_WAIT & ~DMem_Ready).
- Priority 1, freeze, same cycle, combinational: PCWrite, IFID_Write, IDEX_Write, EXMEM_Write = 0; MEMWB_Bubble = 1. Branch flush and load-use are suppressed.
- Priority 2, taken and no freeze, same cycle: IF_Flush = 1, ID_Control_NOP = 1, EX_Flush = 1. Write enables stay 1. Load-use is ignored.
- Priority 3, lu with no freeze and no taken: PCWrite = 0, IFID_Write = 0, ID_Control_NOP = 1. The load advances to MEM next cycle, so the stall lasts exactly 1 cycle.
- FSM, registered on Clk:
  - RUN -> MEM_WAIT when mem_acc & ~DMem_Ready.
  - MEM_WAIT -> RUN when DMem_Ready. That cycle is not frozen; the pipeline advances.
  - MEM_WAIT -> TIMEOUT_REL when wait_cnt reaches MEM_TIMEOUT-1 without DMem_Ready. Set MemTimeout_Err.
  - TIMEOUT_REL: force release. Freeze is inhibited for one cycle and the access is abandoned. Unconditionally -> RUN.
- wait_cnt (8 bit) clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- Counters:
  - StallCount += 1 on every cycle with freeze or load-use stall.
  - FlushCount += 1 on every cycle with taken and no freeze.
  - Both saturate at all-ones and never wrap.
- A branch held in MEM during a freeze is counted once, in the cycle it finally flushes.
- MemTimeout_Err is sticky; only Reset clears it.
- Reset, asynchronous, active-high, any time including mid-MEM_WAIT:
  - state = RUN, wait_cnt = 0, counters = 0, MemTimeout_Err = 0.
  - While Reset is high: all write enables 0, ID_Control_NOP = 1, IF_Flush = 0, EX_Flush = 0, MEMWB_Bubble = 1.
- Source register $0 never causes a load-use stall.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, NOP 100000.
  - hazard state encodings.
- One natural sub-module, sat_counter (parameter W; inc, clear). Instantiate it twice.
- Load-use compare and FSM stay in the top module.

Test Plan:
- Load-use:
  - Stimulus: MemRead_EX=1, RegisterRt_EX=5, Opcode_ID=000000, RegisterRs_ID=5.
  - Response: PCWrite=0, IFID_Write=0, ID_Control_NOP=1 for 1 cycle; StallCount 0->1.
  - Repeat with RegisterRt_EX=0: no stall.
- LW rt not a source:
  - Stimulus: MemRead_EX=1, RegisterRt_EX=7, Opcode_ID=100011, RegisterRt_ID=7, RegisterRs_ID=3.
  - Response: no stall.
- Branch taken:
  - Stimulus: Branch_MEM=1, Zero_MEM=1, with lu simultaneously true.
  - Response: IF_Flush=1, EX_Flush=1, ID_Control_NOP=1, PCWrite=1; FlushCount=1; StallCount unchanged.
- Memory wait:
  - Stimulus: MemRead_MEM=1, DMem_Ready low for 3 cycles, then high.
  - Response: 3 frozen cycles (enables 0, MEMWB_Bubble=1); Hazard_State 0->1->1->1->0; StallCount=3.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, DMem_Ready held 0.
  - Response: 4 frozen cycles; then TIMEOUT_REL with enables 1; MemTimeout_Err=1 and it stays set.
- Reset in MEM_WAIT:
  - Stimulus: assert Reset asynchronously mid-wait.
  - Response: immediately Hazard_State=0, counters=0, ID_Control_NOP=1, enables 0; normal operation on the first edge after release.
